// File: rtl/regwr_pkg.sv
// regwr_pkg: shared types and constants for the register-file write controller.
//   regwr_state_e : controller states (S_CLEAR sweep, S_RUN normal traffic)
//   DEF_*         : default geometry of the RISC-V integer register file
//   ZERO_REG      : index of the hard-wired zero register, never written
//   count_w()     : width of an occupancy counter able to hold 0..depth
package regwr_pkg;

  typedef enum logic [0:0] {
    S_CLEAR,
    S_RUN
  } regwr_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_REG     = 0;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/regwr_fifo.sv
// regwr_fifo: small synchronous in-order FIFO for buffered writeback requests.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   push, wdata    : enqueue wdata (ignored when full)
//   pop, rdata     : dequeue; rdata always shows the head entry
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
module regwr_fifo
  import regwr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO never accepts, even when the head leaves on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: write-side master of the integer register file.
// Buffers writeback requests in an in-order FIFO, drops writes to x0 and,
// when REGWR_CLEAR_EN is defined, sweeps x1..x(NUM_REGS-1) to zero after
// every reset before accepting traffic. Without REGWR_CLEAR_EN the block
// starts directly in S_RUN and o_Init_Done is constantly 1.
// Ports:
//   i_Clk, i_Rst            : clock, asynchronous active-high reset
//   i_Enb                   : global enable, 0 freezes the block
//   i_Req_Valid/o_Req_Ready : request handshake, iv_Req_Addr/iv_Req_Data payload
//   oW_Enb, ov_Write_R,
//   ov_Write_Data           : registered register-file write port
//   o_Init_Done             : clear sweep finished
//   o_Busy                  : sweep active or requests pending
//   ov_Count                : FIFO occupancy
module regfile_write_ctrl
  import regwr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Enb,
  input  logic                           i_Req_Valid,
  input  logic [ADDR_W-1:0]              iv_Req_Addr,
  input  logic [DATA_W-1:0]              iv_Req_Data,
  output logic                           o_Req_Ready,
  output logic                           oW_Enb,
  output logic [ADDR_W-1:0]              ov_Write_R,
  output logic [DATA_W-1:0]              ov_Write_Data,
  output logic                           o_Init_Done,
  output logic                           o_Busy,
  output logic [count_w(FIFO_DEPTH)-1:0] ov_Count
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic             run;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] fifo_head;

`ifdef REGWR_CLEAR_EN
  regwr_state_e      state;
  logic [ADDR_W-1:0] sweep_idx;

  assign run = (state == S_RUN);
`else
  assign run = 1'b1;
`endif

  // Ready is masked during reset so nothing is advertised before release.
  assign o_Req_Ready = ~i_Rst & run & i_Enb & ~fifo_full;
  // x0 requests complete the handshake but are never stored.
  assign fifo_push   = i_Req_Valid & o_Req_Ready & (iv_Req_Addr != ADDR_W'(ZERO_REG));
  assign fifo_pop    = run & i_Enb & ~fifo_empty;
  assign o_Busy      = i_Rst | ~run | (ov_Count != '0);

  regwr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .push  (fifo_push),
    .wdata ({iv_Req_Addr, iv_Req_Data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ov_Count)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      oW_Enb        <= 1'b0;
      ov_Write_R    <= '0;
      ov_Write_Data <= '0;
`ifdef REGWR_CLEAR_EN
      o_Init_Done   <= 1'b0;
      state         <= S_CLEAR;
      sweep_idx     <= ADDR_W'(1);
`else
      o_Init_Done   <= 1'b1;
`endif
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold otherwise.
      oW_Enb <= 1'b0;
      if (fifo_pop) begin
        oW_Enb        <= 1'b1;
        ov_Write_R    <= fifo_head[DATA_W +: ADDR_W];
        ov_Write_Data <= fifo_head[DATA_W-1:0];
      end
`ifdef REGWR_CLEAR_EN
      if (i_Enb && state == S_CLEAR) begin
        oW_Enb        <= 1'b1;
        ov_Write_R    <= sweep_idx;
        ov_Write_Data <= '0;
        sweep_idx     <= sweep_idx + 1'b1;
        if (sweep_idx == ADDR_W'(NUM_REGS - 1)) begin
          state       <= S_RUN;
          o_Init_Done <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model and a
// shadow register file.
module tb_regfile_write_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int DEPTH  = 4;
`ifdef REGWR_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              enb;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              w_enb;
  logic [ADDR_W-1:0] w_r;
  logic [DATA_W-1:0] w_data;
  logic              init_done;
  logic              busy;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t              q[$];
  bit                m_run;
  bit                m_init;
  int                m_sweep;
  bit                e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  logic [DATA_W-1:0] rf_m [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  regfile_write_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_REGS   (NREGS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Enb         (enb),
    .i_Req_Valid   (req_valid),
    .iv_Req_Addr   (req_addr),
    .iv_Req_Data   (req_data),
    .o_Req_Ready   (req_ready),
    .oW_Enb        (w_enb),
    .ov_Write_R    (w_r),
    .ov_Write_Data (w_data),
    .o_Init_Done   (init_done),
    .o_Busy        (busy),
    .ov_Count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run   = !CLR;
    m_init  = !CLR;
    m_sweep = 1;
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
  endtask

  // Entered and left at posedge+1; reset is asserted asynchronously.
  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_wenb", w_enb, 1'b0);
    check("rst_addr", w_r, '0);
    check("rst_data", w_data, '0);
    check("rst_init", init_done, m_init);
    check("rst_count", count, 3'd0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check handshake side, clock, check write port.
  task automatic do_cycle(input bit valid, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input bit en);
    bit   exp_ready;
    ent_t e;
    req_valid = valid;
    req_addr  = addr;
    req_data  = data;
    enb       = en;
    #1;
    exp_ready = m_run && en && (q.size() < DEPTH);
    check("ready", req_ready, exp_ready);
    check("count", count, q.size());
    check("busy", busy, (!m_run) || (q.size() != 0));
    check("init", init_done, m_init);
    @(posedge clk);
    e_we = 1'b0;
    if (en) begin
      if (!m_run) begin
        e_we   = 1'b1;
        e_addr = ADDR_W'(m_sweep);
        e_data = '0;
        rf_m[m_sweep] = '0;
        if (m_sweep == NREGS - 1) begin
          m_run  = 1'b1;
          m_init = 1'b1;
        end
        m_sweep++;
      end else begin
        if (q.size() > 0) begin
          e = q.pop_front();
          e_we   = 1'b1;
          e_addr = e.a;
          e_data = e.d;
          rf_m[e.a] = e.d;
        end
        if (valid && exp_ready && addr != 0) begin
          e.a = addr;
          e.d = data;
          q.push_back(e);
        end
      end
    end
    #1;
    check("wenb", w_enb, e_we);
    check("waddr", w_r, e_addr);
    check("wdata", w_data, e_data);
    check("init_post", init_done, m_init);
    if (w_enb === 1'b1 && !$isunknown(w_r)) rf_d[w_r] = w_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    int   k;
    bit   en;
    logic [ADDR_W-1:0] a;
    rst       = 1'b1;
    enb       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NREGS; i++) begin
      rf_m[i] = 32'hBAD0_0000 | i;
      rf_d[i] = 32'hBAD0_0000 | i;
    end
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset(10);

    // Default build: a request in the very first cycle after release.
    do_cycle(1'b1, 5'd5, 32'd7, 1'b1);
    idle(2);

    // Clear sweep (a no-op in the default build).
    idle(33);

    // Single request and its write pulse.
    do_cycle(1'b1, 5'd10, 32'd123456789, 1'b1);
    idle(3);

    // Burst of six with an enable gap in the middle; each held until accepted.
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      en = !(c >= 2 && c < 5);
      a  = ADDR_W'(k + 1);
      if (m_run && en && q.size() < DEPTH) begin
        do_cycle(1'b1, a, 32'(100 + k + 1), en);
        k++;
      end else begin
        do_cycle(1'b1, a, 32'(100 + k + 1), en);
      end
    end
    check("burst_accepted", k, 6);
    idle(4);

    // Write to x0 is consumed but never issued.
    do_cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
    idle(3);

    // Same index twice: last one wins.
    do_cycle(1'b1, 5'd12, 32'h1111, 1'b1);
    do_cycle(1'b1, 5'd12, 32'h2222, 1'b1);
    idle(3);

    // Reset with traffic in flight, then reset again mid-sweep.
    do_cycle(1'b1, 5'd20, 32'h20, 1'b1);
    do_cycle(1'b1, 5'd21, 32'h21, 1'b0);
    do_cycle(1'b1, 5'd22, 32'h22, 1'b0);
    pulse_reset(3);
    idle(10);
    pulse_reset(2);
    idle(33);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else begin
        a = ($urandom_range(0, 9) == 0) ? 5'd0 : ADDR_W'($urandom_range(1, NREGS - 1));
        do_cycle($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 4) != 0);
      end
    end
    idle(40);

    for (int i = 0; i < NREGS; i++) check($sformatf("rf[%0d]", i), rf_d[i], rf_m[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
